// File: rtl/sw_duty_pkg.sv
// sw_duty_pkg: shared duty-code types and the one-LSB slew step helper.
package sw_duty_pkg;
    localparam int DUTY_W = 3;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 3'd7;

    typedef logic [DUTY_W-1:0] duty_t;

    // Moves cur one LSB toward tgt, clamped to the legal code range.
    function automatic duty_t step_toward(duty_t cur, duty_t tgt);
        return (cur < tgt && cur != DUTY_MAX) ? duty_t'(cur + 1'b1) :
               (cur > tgt && cur != '0)       ? duty_t'(cur - 1'b1) : cur;
    endfunction
endpackage

// File: rtl/sw_sync_debounce.sv
// sw_sync_debounce: 2-flop synchroniser plus stability debounce for a W-bit switch bank.
module sw_sync_debounce #(
    parameter int W         = 3,
    parameter int DB_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_i,
    output logic [W-1:0] target_o
);
    localparam int CW = $clog2(DB_CYCLES);

    logic [W-1:0]  s1_q, s2_q, cand_q, cand_d, target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          settled;

    // The counter saturates at DB_CYCLES-1 so a long-held value keeps re-asserting target harmlessly.
    always_comb begin
        settled  = s2_q == cand_q && cnt_q == CW'(DB_CYCLES - 1);
        cand_d   = s2_q;
        cnt_d    = (s2_q != cand_q) ? '0 : settled ? cnt_q : cnt_q + 1'b1;
        target_d = settled ? cand_q : target_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            s1_q     <= sw_i;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    assign target_o = target_q;
endmodule

// File: rtl/sw_duty_ctrl.sv
// sw_duty_ctrl: debounced switch setting turned into the 3-bit PWM duty code.
// DUTY_RAMP_EN enables one-LSB-per-RAMP_DIV slewing; otherwise duty follows target one edge later.
module sw_duty_ctrl
    import sw_duty_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int RAMP_DIV  = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_raw,
    output logic [2:0] duty,
    output logic       duty_upd,
    output logic       ramping
);
    duty_t target, duty_q, duty_d;
    logic  upd_q, upd_d;

    sw_sync_debounce #(.W(DUTY_W), .DB_CYCLES(DB_CYCLES)) u_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (sw_raw),
        .target_o(target)
    );

`ifdef DUTY_RAMP_EN
    localparam int PW = $clog2(RAMP_DIV);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // Prescaler free-runs only while ramping, so a mid-ramp reversal keeps its phase.
    always_comb begin
        ramping = duty_q != target;
        tick    = ramping && pre_q == PW'(RAMP_DIV - 1);
        pre_d   = (ramping && !tick) ? pre_q + 1'b1 : '0;
        duty_d  = tick ? step_toward(duty_q, target) : duty_q;
        upd_d   = tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end
`else
    logic unused_ramp_div;
    assign unused_ramp_div = ^RAMP_DIV;

    always_comb begin
        duty_d  = target;
        upd_d   = duty_q != target;
        ramping = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            upd_q  <= upd_d;
        end
    end

    assign duty     = duty_q;
    assign duty_upd = upd_q;
endmodule
